// File: rtl/fixed_point_pkg.sv
// Shared fixed-point constants and the arg-max FSM state type.
package fixed_point_pkg;

  localparam int unsigned FP_WIDTH     = 8;
  localparam int unsigned FP_FRAC_BITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/fixed_point_argmax_if.sv
// Handshake/result bundle for the streaming arg-max stage.
//   START_IN      : frame-open pulse (master -> slave)
//   VALUE_IN      : signed fixed-point sample
//   VALID_IN      : VALUE_IN is valid
//   READY_OUT     : slave accepts a sample this cycle
//   MAX_VALUE_OUT : maximum of the last completed frame
//   MAX_INDEX_OUT : 0-based position of that maximum
//   DONE_OUT      : one-cycle frame-complete pulse
//   BUSY_OUT      : frame in progress
interface fixed_point_argmax_if
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH     = FP_WIDTH,
  parameter int unsigned IDX_WIDTH = 4
);

  logic                 START_IN;
  logic [WIDTH-1:0]     VALUE_IN;
  logic                 VALID_IN;
  logic                 READY_OUT;
  logic [WIDTH-1:0]     MAX_VALUE_OUT;
  logic [IDX_WIDTH-1:0] MAX_INDEX_OUT;
  logic                 DONE_OUT;
  logic                 BUSY_OUT;

  modport master (
    output START_IN, VALUE_IN, VALID_IN,
    input  READY_OUT, MAX_VALUE_OUT, MAX_INDEX_OUT, DONE_OUT, BUSY_OUT
  );

  modport slave (
    input  START_IN, VALUE_IN, VALID_IN,
    output READY_OUT, MAX_VALUE_OUT, MAX_INDEX_OUT, DONE_OUT, BUSY_OUT
  );

endinterface

// File: rtl/fixed_point_argmax_comp.sv
// Combinational signed fixed-point comparator (A vs B).
//   a_i, b_i : signed two's-complement operands
//   gt_c     : a_i > b_i
//   eq_c     : a_i == b_i
//   lt_c     : a_i < b_i
module FIXED_POINT_COMP
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH     = FP_WIDTH,
  parameter int unsigned FRAC_BITS = FP_FRAC_BITS
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic                    gt_c,
  output logic                    eq_c,
  output logic                    lt_c
);

  if (FRAC_BITS == 0) begin : g_int_only
    always_comb begin
      gt_c = (a_i > b_i);
      eq_c = (a_i == b_i);
      lt_c = (a_i < b_i);
    end
  end else begin : g_split
    localparam int unsigned INT_W = WIDTH - FRAC_BITS;

    // Signed integer part decides first; unsigned fraction breaks ties.
    logic signed [INT_W-1:0]     a_int, b_int;
    logic        [FRAC_BITS-1:0] a_frac, b_frac;

    assign a_int  = a_i[WIDTH-1:FRAC_BITS];
    assign b_int  = b_i[WIDTH-1:FRAC_BITS];
    assign a_frac = a_i[FRAC_BITS-1:0];
    assign b_frac = b_i[FRAC_BITS-1:0];

    always_comb begin
      gt_c = (a_int > b_int) || ((a_int == b_int) && (a_frac > b_frac));
      eq_c = (a_int == b_int) && (a_frac == b_frac);
      lt_c = !gt_c && !eq_c;
    end
  end

endmodule

// File: rtl/fixed_point_argmax.sv
// Streaming arg-max over a frame of NUM_INPUTS signed fixed-point samples.
//   CLK, RST : rising-edge clock, synchronous active-high reset
//   bus      : slave side of fixed_point_argmax_if (samples in, result out)
module fixed_point_argmax
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH      = FP_WIDTH,
  parameter int unsigned FRAC_BITS  = FP_FRAC_BITS,
  parameter int unsigned NUM_INPUTS = 10,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic               CLK,
  input  logic               RST,
  fixed_point_argmax_if.slave bus
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

  argmax_state_t         state_q, state_d;
  logic [IDX_WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]      held_val_q, held_val_d;
  logic [IDX_WIDTH-1:0]  held_idx_q, held_idx_d;
  logic [WIDTH-1:0]      max_val_q, max_val_d;
  logic [IDX_WIDTH-1:0]  max_idx_q, max_idx_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic                  accept_c;
  logic                  gt_c;
  logic                  cmp_eq_unused;
  logic                  cmp_lt_unused;

  // New sample against the running maximum.
  FIXED_POINT_COMP #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_comp (
    .a_i  (bus.VALUE_IN),
    .b_i  (held_val_q),
    .gt_c (gt_c),
    .eq_c (cmp_eq_unused),
    .lt_c (cmp_lt_unused)
  );

  assign accept_c = bus.VALID_IN && ready_q;

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      count_q    <= '0;
      held_val_q <= '0;
      held_idx_q <= '0;
      max_val_q  <= '0;
      max_idx_q  <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      held_val_q <= held_val_d;
      held_idx_q <= held_idx_d;
      max_val_q  <= max_val_d;
      max_idx_q  <= max_idx_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    held_val_d = held_val_q;
    held_idx_d = held_idx_q;
    max_val_d  = max_val_q;
    max_idx_d  = max_idx_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.START_IN) begin
          state_d = ACCUM;
          count_d = '0;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          // First sample seeds the max; later ones must be strictly greater.
          if (count_q == '0 || gt_c) begin
            held_val_d = bus.VALUE_IN;
            held_idx_d = count_q;
          end
          if (count_q == LAST_IDX) begin
            state_d   = DONE;
            count_d   = '0;
            done_d    = 1'b1;
            max_val_d = held_val_d;
            max_idx_d = held_idx_d;
          end else begin
            count_d = count_q + IDX_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == ACCUM);
    busy_d  = (state_d == ACCUM);
  end

  assign bus.READY_OUT     = ready_q;
  assign bus.BUSY_OUT      = busy_q;
  assign bus.DONE_OUT      = done_q;
  assign bus.MAX_VALUE_OUT = max_val_q;
  assign bus.MAX_INDEX_OUT = max_idx_q;

endmodule

// File: tb/tb_fixed_point_argmax.sv
// Directed, table-driven bench for fixed_point_argmax (NUM_INPUTS = 10).
module tb_fixed_point_argmax;
  import fixed_point_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 10;
  localparam int unsigned IW = 4;

  typedef struct {
    logic [N-1:0][W-1:0] vals;
    logic [W-1:0]        exp_max;
    logic [IW-1:0]       exp_idx;
    bit                  throttle;
    int                  mid_start;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  fixed_point_argmax_if #(.WIDTH(W), .IDX_WIDTH(IW)) bus ();

  fixed_point_argmax #(
    .WIDTH      (W),
    .FRAC_BITS  (3),
    .NUM_INPUTS (N),
    .IDX_WIDTH  (IW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  prev_max;
  logic [IW-1:0] prev_idx;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, a9,
                              input logic [W-1:0] em, input logic [IW-1:0] ei,
                              input bit thr, input int ms);
    vec_t r;
    r.vals[0] = a0; r.vals[1] = a1; r.vals[2] = a2; r.vals[3] = a3; r.vals[4] = a4;
    r.vals[5] = a5; r.vals[6] = a6; r.vals[7] = a7; r.vals[8] = a8; r.vals[9] = a9;
    r.exp_max   = em;
    r.exp_idx   = ei;
    r.throttle  = thr;
    r.mid_start = ms;
    return r;
  endfunction

  // Open a frame, stream all samples, then check the result on the DONE_OUT cycle.
  task automatic run_frame(input vec_t v);
    bit acc;
    int budget;
    bus.START_IN = 1'b1;
    tick();
    bus.START_IN = 1'b0;
    check("busy_after_start", 32'(bus.BUSY_OUT), 32'd1);
    check("ready_after_start", 32'(bus.READY_OUT), 32'd1);
    for (int i = 0; i < int'(N); i++) begin
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
        bus.VALID_IN = v.throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.VALUE_IN = bus.VALID_IN ? v.vals[i] : 8'($urandom);
        bus.START_IN = (i == v.mid_start);
        acc = bus.VALID_IN && bus.READY_OUT;
        tick();
        bus.START_IN = 1'b0;
        budget++;
      end
      if (!acc) begin
        check("accept_timeout", 32'd0, 32'd1);
        bus.VALID_IN = 1'b0;
        return;
      end
      if (i < int'(N) - 1) begin
        check("no_early_done", 32'(bus.DONE_OUT), 32'd0);
        check("max_val_held_in_accum", 32'(bus.MAX_VALUE_OUT), 32'(prev_max));
        check("max_idx_held_in_accum", 32'(bus.MAX_INDEX_OUT), 32'(prev_idx));
      end
    end
    bus.VALID_IN = 1'b0;
    check("done_pulse", 32'(bus.DONE_OUT), 32'd1);
    check("max_value", 32'(bus.MAX_VALUE_OUT), 32'(v.exp_max));
    check("max_index", 32'(bus.MAX_INDEX_OUT), 32'(v.exp_idx));
    check("busy_in_done", 32'(bus.BUSY_OUT), 32'd0);
    check("ready_in_done", 32'(bus.READY_OUT), 32'd0);
    prev_max = v.exp_max;
    prev_idx = v.exp_idx;
  endtask

  initial begin
    tbl[0] = mk(8'h08, 8'h10, 8'hF0, 8'h30, 8'h18, 8'h00, 8'h2F, 8'h01, 8'h02, 8'h03, 8'h30, 4'd3, 1'b0, -1);
    tbl[1] = mk(8'hF8, 8'h80, 8'hFF, 8'hC0, 8'hF0, 8'h90, 8'hA0, 8'hFE, 8'h81, 8'hE0, 8'hFF, 4'd2, 1'b0, -1);
    tbl[2] = mk(8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89, 8'h89, 4'd9, 1'b0, -1);
    tbl[3] = mk(8'h10, 8'h20, 8'h05, 8'h1F, 8'h20, 8'h00, 8'hF0, 8'h1E, 8'h11, 8'h20, 8'h20, 4'd1, 1'b1, -1);
    tbl[4] = mk(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h7F, 8'h7F, 4'd9, 1'b0, -1);
    tbl[5] = mk(8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 4'd0, 1'b1, -1);
    tbl[6] = mk(8'h7F, 8'h00, 8'h80, 8'h7F, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h7F, 4'd0, 1'b0, -1);
    tbl[7] = mk(8'h08, 8'h10, 8'hF0, 8'h30, 8'h18, 8'h00, 8'h2F, 8'h01, 8'h02, 8'h03, 8'h30, 4'd3, 1'b1, 5);

    bus.START_IN = 1'b0;
    bus.VALID_IN = 1'b0;
    bus.VALUE_IN = '0;
    prev_max     = '0;
    prev_idx     = '0;

    // Reset, then VALID_IN without START_IN must not be accepted.
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    bus.VALID_IN = 1'b1;
    bus.VALUE_IN = 8'h42;
    check("rst_ready", 32'(bus.READY_OUT), 32'd0);
    check("rst_done", 32'(bus.DONE_OUT), 32'd0);
    check("rst_busy", 32'(bus.BUSY_OUT), 32'd0);
    check("rst_max_value", 32'(bus.MAX_VALUE_OUT), 32'd0);
    check("rst_max_index", 32'(bus.MAX_INDEX_OUT), 32'd0);
    tick();
    tick();
    check("idle_ignores_valid_ready", 32'(bus.READY_OUT), 32'd0);
    check("idle_ignores_valid_busy", 32'(bus.BUSY_OUT), 32'd0);
    bus.VALID_IN = 1'b0;

    // Table frames, each followed by an idle cycle checking the pulse width.
    for (int k = 0; k < 8; k++) begin
      run_frame(tbl[k]);
      tick();
      check("done_one_cycle", 32'(bus.DONE_OUT), 32'd0);
      check("max_value_stable", 32'(bus.MAX_VALUE_OUT), 32'(tbl[k].exp_max));
      check("max_index_stable", 32'(bus.MAX_INDEX_OUT), 32'(tbl[k].exp_idx));
    end

    // START_IN on the DONE_OUT cycle: previous result must hold during the next frame.
    run_frame(tbl[1]);
    run_frame(tbl[4]);
    tick();
    check("b2b_done_one_cycle", 32'(bus.DONE_OUT), 32'd0);

    // Reset after 5 accepts aborts the frame.
    bus.START_IN = 1'b1;
    tick();
    bus.START_IN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.VALID_IN = 1'b1;
      bus.VALUE_IN = 8'h7F;
      tick();
    end
    bus.VALID_IN = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("midrst_ready", 32'(bus.READY_OUT), 32'd0);
    check("midrst_busy", 32'(bus.BUSY_OUT), 32'd0);
    check("midrst_done", 32'(bus.DONE_OUT), 32'd0);
    check("midrst_max_value", 32'(bus.MAX_VALUE_OUT), 32'd0);
    check("midrst_max_index", 32'(bus.MAX_INDEX_OUT), 32'd0);
    prev_max = '0;
    prev_idx = '0;
    bus.VALID_IN = 1'b1;
    tick();
    check("midrst_stays_idle", 32'(bus.READY_OUT), 32'd0);
    bus.VALID_IN = 1'b0;
    run_frame(tbl[0]);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
